// File: rtl/ir_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ir_action_ctrl
// Purpose  : Maps validated IR key frames to a latched drive action, a control
//            mode, a display page select and a saturating speed level. A
//            watchdog forces a stop when key frames stop arriving while the
//            car is moving.
// Ports    : clk_in       - single rising-edge clock
//            rst          - synchronous active-high reset
//            frame_valid  - one-cycle strobe qualifying frame_data
//            frame_data   - decoded IR key code (DATA_W bits)
//            action       - drive command (2 fwd, 4 left, 5 right, A back, F stop)
//            action_stb   - one-cycle pulse whenever action changes value
//            car_mode     - 0 manual, 1/2 autonomous, 3 idle
//            seg_sel      - display page select
//            speed_level  - current speed step (saturating)
//            timeout      - sticky watchdog-stop flag
// Revision : 1.0 - initial release
// ============================================================================
module ir_action_ctrl #(
    parameter int DATA_W       = 8,
    parameter int SPEED_LEVELS = 4,
    parameter int SPEED_INIT   = 1,
    parameter int TIMEOUT_CYC  = 1_000_000
) (
    input  logic                            clk_in,
    input  logic                            rst,
    input  logic                            frame_valid,
    input  logic [DATA_W-1:0]               frame_data,
    output logic [3:0]                      action,
    output logic                            action_stb,
    output logic [1:0]                      car_mode,
    output logic [2:0]                      seg_sel,
    output logic [$clog2(SPEED_LEVELS)-1:0] speed_level,
    output logic                            timeout
);

    localparam int SPD_W = $clog2(SPEED_LEVELS);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [SPD_W-1:0] c_SPD_MAX  = SPD_W'(SPEED_LEVELS - 1);
    localparam logic [SPD_W-1:0] c_SPD_INIT = SPD_W'(SPEED_INIT);
    localparam logic [CNT_W-1:0] c_WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] c_ACT_FWD   = 4'h2;
    localparam logic [3:0] c_ACT_LEFT  = 4'h4;
    localparam logic [3:0] c_ACT_RIGHT = 4'h5;
    localparam logic [3:0] c_ACT_BACK  = 4'hA;
    localparam logic [3:0] c_ACT_STOP  = 4'hF;

    localparam logic [DATA_W-1:0] c_KEY_MODE0  = DATA_W'(8'h45);
    localparam logic [DATA_W-1:0] c_KEY_MODE1  = DATA_W'(8'h46);
    localparam logic [DATA_W-1:0] c_KEY_MODE2  = DATA_W'(8'h47);
    localparam logic [DATA_W-1:0] c_KEY_MANSEG = DATA_W'(8'h16);
    localparam logic [DATA_W-1:0] c_KEY_SEG3   = DATA_W'(8'h44);
    localparam logic [DATA_W-1:0] c_KEY_SEG2   = DATA_W'(8'h40);
    localparam logic [DATA_W-1:0] c_KEY_SEG1   = DATA_W'(8'h43);
    localparam logic [DATA_W-1:0] c_KEY_FWD    = DATA_W'(8'h18);
    localparam logic [DATA_W-1:0] c_KEY_LEFT   = DATA_W'(8'h08);
    localparam logic [DATA_W-1:0] c_KEY_RIGHT  = DATA_W'(8'h5A);
    localparam logic [DATA_W-1:0] c_KEY_BACK   = DATA_W'(8'h52);
    localparam logic [DATA_W-1:0] c_KEY_STOP   = DATA_W'(8'h1C);
    localparam logic [DATA_W-1:0] c_KEY_SPDUP  = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] c_KEY_SPDDN  = DATA_W'(8'h19);

    typedef enum logic [1:0] {
        S_STOP    = 2'd0,
        S_RUN     = 2'd1,
        S_HALT_TO = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_action;
    logic             r_action_stb;
    logic [1:0]       r_car_mode;
    logic [2:0]       r_seg_sel;
    logic [SPD_W-1:0] r_speed;
    logic             r_timeout;
    logic [CNT_W-1:0] r_wd_cnt;

    logic [3:0]       w_move_act;

    // Drive code for the movement keys; only meaningful when the key is one.
    always_comb begin
        w_move_act = c_ACT_STOP;
        case (frame_data)
            c_KEY_FWD:   w_move_act = c_ACT_FWD;
            c_KEY_LEFT:  w_move_act = c_ACT_LEFT;
            c_KEY_RIGHT: w_move_act = c_ACT_RIGHT;
            c_KEY_BACK:  w_move_act = c_ACT_BACK;
            default:     w_move_act = c_ACT_STOP;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= S_STOP;
            r_action     <= c_ACT_STOP;
            r_action_stb <= 1'b0;
            r_car_mode   <= 2'b11;
            r_seg_sel    <= 3'b000;
            r_speed      <= c_SPD_INIT;
            r_timeout    <= 1'b0;
            r_wd_cnt     <= '0;
        end else begin
            r_action_stb <= 1'b0;
            if (frame_valid) begin
                // Any frame refreshes the watchdog and clears the sticky flag.
                r_timeout <= 1'b0;
                r_wd_cnt  <= '0;
                // Leaving HALT_TO: a non-movement frame lands in STOP; an
                // accepted movement key below overrides this with RUN.
                if (r_state == S_HALT_TO) begin
                    r_state <= S_STOP;
                end
                case (frame_data)
                    c_KEY_MODE0: r_car_mode <= 2'd0;
                    c_KEY_MODE1, c_KEY_MODE2: begin
                        r_car_mode   <= (frame_data == c_KEY_MODE1) ? 2'd1 : 2'd2;
                        r_state      <= S_STOP;
                        r_action     <= c_ACT_STOP;
                        r_action_stb <= (r_action != c_ACT_STOP);
                    end
                    c_KEY_MANSEG: begin
                        r_car_mode <= 2'd0;
                        r_seg_sel  <= 3'b010;
                    end
                    c_KEY_SEG3: r_seg_sel <= 3'b011;
                    c_KEY_SEG2: r_seg_sel <= 3'b010;
                    c_KEY_SEG1: r_seg_sel <= 3'b001;
                    c_KEY_FWD, c_KEY_LEFT, c_KEY_RIGHT, c_KEY_BACK: begin
                        if (r_car_mode == 2'd0) begin
                            r_state      <= S_RUN;
                            r_action     <= w_move_act;
                            r_action_stb <= (r_action != w_move_act);
                        end
                    end
                    c_KEY_STOP: begin
                        r_state      <= S_STOP;
                        r_action     <= c_ACT_STOP;
                        r_action_stb <= (r_action != c_ACT_STOP);
                    end
                    c_KEY_SPDUP: begin
                        if (r_speed != c_SPD_MAX) begin
                            r_speed <= r_speed + 1'b1;
                        end
                    end
                    c_KEY_SPDDN: begin
                        if (r_speed != '0) begin
                            r_speed <= r_speed - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (r_state == S_RUN) begin
                // The compare stops the counter before it could ever wrap.
                if (r_wd_cnt == c_WD_LAST) begin
                    r_state      <= S_HALT_TO;
                    r_timeout    <= 1'b1;
                    r_action     <= c_ACT_STOP;
                    r_action_stb <= (r_action != c_ACT_STOP);
                    r_wd_cnt     <= '0;
                end else begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign action      = r_action;
    assign action_stb  = r_action_stb;
    assign car_mode    = r_car_mode;
    assign seg_sel     = r_seg_sel;
    assign speed_level = r_speed;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ir_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_action_ctrl
// Purpose  : Self-checking bench for ir_action_ctrl. A table-driven reference
//            model predicts every cycle's outputs into a queue; a monitor pops
//            and compares one cycle after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_action_ctrl;

    localparam int DATA_W       = 8;
    localparam int SPEED_LEVELS = 4;
    localparam int SPEED_INIT   = 1;
    localparam int TIMEOUT_CYC  = 16;
    localparam int SPD_W        = $clog2(SPEED_LEVELS);

    logic              clk_in      = 1'b0;
    logic              rst         = 1'b1;
    logic              frame_valid = 1'b0;
    logic [DATA_W-1:0] frame_data  = '0;
    logic [3:0]        action;
    logic              action_stb;
    logic [1:0]        car_mode;
    logic [2:0]        seg_sel;
    logic [SPD_W-1:0]  speed_level;
    logic              timeout;

    always #5 clk_in = ~clk_in;

    ir_action_ctrl #(
        .DATA_W       (DATA_W),
        .SPEED_LEVELS (SPEED_LEVELS),
        .SPEED_INIT   (SPEED_INIT),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) u_dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .action      (action),
        .action_stb  (action_stb),
        .car_mode    (car_mode),
        .seg_sel     (seg_sel),
        .speed_level (speed_level),
        .timeout     (timeout)
    );

    typedef struct packed {
        logic [3:0]       act;
        logic             stb;
        logic [1:0]       mode;
        logic [2:0]       seg;
        logic [SPD_W-1:0] spd;
        logic             to;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Reference model state, kept as plain integers and flags.
    int m_action, m_mode, m_seg, m_speed, m_idle;
    bit m_timeout, m_running;
    int key_mode[int];
    int key_seg[int];
    int key_move[int];
    int key_list[$];

    task automatic model_reset();
        m_action  = 15;
        m_mode    = 3;
        m_seg     = 0;
        m_speed   = SPEED_INIT;
        m_timeout = 0;
        m_running = 0;
        m_idle    = 0;
    endtask

    task automatic model_step(input bit r, input bit fv, input int d);
        int   old_act;
        exp_t e;
        old_act = m_action;
        if (r) begin
            model_reset();
        end else if (fv) begin
            m_idle    = 0;
            m_timeout = 0;
            if (key_mode.exists(d)) begin
                m_mode = key_mode[d];
                if (m_mode != 0) begin
                    m_action  = 15;
                    m_running = 0;
                end
            end
            if (key_seg.exists(d)) m_seg = key_seg[d];
            if (key_move.exists(d) && m_mode == 0) begin
                m_action  = key_move[d];
                m_running = 1;
            end
            if (d == 'h1C) begin
                m_action  = 15;
                m_running = 0;
            end
            if (d == 'h0D && m_speed < SPEED_LEVELS - 1) m_speed++;
            if (d == 'h19 && m_speed > 0) m_speed--;
        end else if (m_running) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
                m_running = 0;
                m_timeout = 1;
                m_action  = 15;
                m_idle    = 0;
            end
        end
        e.act  = 4'(m_action);
        e.stb  = !r && (m_action != old_act);
        e.mode = 2'(m_mode);
        e.seg  = 3'(m_seg);
        e.spd  = SPD_W'(m_speed);
        e.to   = m_timeout;
        q_exp.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit fv, input logic [7:0] d);
        @(negedge clk_in);
        rst         = r;
        frame_valid = fv;
        frame_data  = fv ? d : 8'($urandom);
        model_step(r, fv, int'(d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(input logic [7:0] d);
        cyc(1'b0, 1'b1, d);
    endtask

    function automatic logic [7:0] pick_key();
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel < 10) return 8'($urandom);
        if (sel < 25) return 8'h45;
        return 8'(key_list[$urandom_range(0, key_list.size() - 1)]);
    endfunction

    // Monitor: one expected record per rising edge, sampled 1 ns after it.
    exp_t e_mon;
    exp_t got;
    always begin
        @(posedge clk_in);
        #1;
        cyc_n++;
        if (q_exp.size() > 0) begin
            e_mon = q_exp.pop_front();
            got   = {action, action_stb, car_mode, seg_sel, speed_level, timeout};
            checks++;
            if (got !== e_mon) begin
                errors++;
                $display("FAIL outputs cyc=%0d got act=%h stb=%b mode=%0d seg=%b spd=%0d to=%b exp act=%h stb=%b mode=%0d seg=%b spd=%0d to=%b",
                         cyc_n, action, action_stb, car_mode, seg_sel, speed_level, timeout,
                         e_mon.act, e_mon.stb, e_mon.mode, e_mon.seg, e_mon.spd, e_mon.to);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        key_mode['h45] = 0;  key_mode['h46] = 1;  key_mode['h47] = 2;  key_mode['h16] = 0;
        key_seg['h16]  = 2;  key_seg['h44]  = 3;  key_seg['h40]  = 2;  key_seg['h43]  = 1;
        key_move['h18] = 2;  key_move['h08] = 4;  key_move['h5A] = 5;  key_move['h52] = 10;
        key_list = '{'h45, 'h46, 'h47, 'h16, 'h44, 'h40, 'h43, 'h18, 'h08, 'h5A, 'h52,
                     'h1C, 'h0D, 'h19, 'h18, 'h08, 'h5A};
        model_reset();

        // Reset, then a movement key in idle mode is ignored.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h18);
        frame(8'h18);
        idle(2);
        frame(8'h45);
        frame(8'h18);
        idle(2);

        // Speed saturation both ways.
        for (int i = 0; i < 6; i++) begin frame(8'h0D); idle(1); end
        for (int i = 0; i < 5; i++) frame(8'h19);

        // Watchdog expiry and recovery.
        frame(8'h08);
        idle(TIMEOUT_CYC + 3);
        frame(8'h5A);
        idle(1);

        // Refresh frame exactly in the expiry cycle.
        frame(8'h18);
        idle(TIMEOUT_CYC - 1);
        frame(8'h18);
        idle(3);

        // Autonomous mode forces stop and blocks movement keys.
        frame(8'h46);
        frame(8'h52);
        frame(8'h43);
        idle(1);

        // Reset wins over a simultaneous stop frame.
        frame(8'h45);
        frame(8'h18);
        frame(8'h0D);
        frame(8'h0D);
        cyc(1'b1, 1'b1, 8'h1C);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2)       cyc(1'b1, 1'($urandom_range(0, 1)), pick_key());
            else if (sel < 14) idle(int'($urandom_range(TIMEOUT_CYC - 4, TIMEOUT_CYC + 4)));
            else if (sel < 60) frame(pick_key());
            else               idle(int'($urandom_range(1, 3)));
        end

        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending exp 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
